hyperram_responder: RTL and testbench

HYPERRAM_RESPONDER -- requirements
Module: hyperram_responder

---
 rtl/hyperram_responder.sv | 202 ++++++++++++++++++++
 tb/tb_hyperram_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hyperram_responder.sv
// HyperBus memory responder: decodes the 48-bit command/address, then serves
// register access, masked memory writes and wrapping linear read bursts.
module hyperram_responder #(
    parameter int          AW        = 10,
    parameter logic [15:0] ID0_VALUE = 16'h0C81
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dram_cs,
    input  logic        dram_ck_en,
    input  logic [15:0] dram_dq_rise,
    input  logic [15:0] dram_dq_fall,
    input  logic [1:0]  dram_rwds_rise,
    input  logic [1:0]  dram_rwds_fall,
    output logic [15:0] dram_dq_out_rise,
    output logic [15:0] dram_dq_out_fall,
    output logic        dram_dq_oe,
    output logic [1:0]  dram_rwds_out_rise,
    output logic [1:0]  dram_rwds_out_fall,
    output logic        dram_rwds_oe,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CA, LAT, WRDATA, RDDATA, REGWR, IGNORE} state_t;

    state_t        state;
    logic          armed;
    logic [1:0]    ck_cnt;
    logic [4:0]    lat_cnt;
    logic [31:0]   ca0_hi, ca1_hi;
    logic [AW-1:0] addr;
    logic          is_rd, is_reg, reg_done;
    logic [1:0]    reg_sel;
    logic [15:0]   cr0, cr1;

    logic [31:0]   mem [0:(2**AW)-1];

    logic [47:0]   ca0, ca1;
    logic [AW-1:0] addr_ca, addr_nxt;
    logic          ca_bad;
    logic [1:0]    sel_d;
    logic [15:0]   sel_val;
    logic [31:0]   pre_word;

    // Full CA as seen while the third CA clock is being presented.
    assign ca0      = {ca0_hi, dram_dq_rise[7:0],  dram_dq_fall[7:0]};
    assign ca1      = {ca1_hi, dram_dq_rise[15:8], dram_dq_fall[15:8]};
    assign addr_ca  = AW'({ca0[44:16], ca0[2:0]});
    assign addr_nxt = addr + AW'(1);
    assign ca_bad   = (ca0 != ca1) || !ca0[45];
    assign sel_d    = !ca0[24] ? 2'd0 : (ca0[16] ? 2'd2 : 2'd1);

    always_comb begin
        sel_val = ID0_VALUE;
        case (sel_d)
            2'd1:    sel_val = cr0;
            2'd2:    sel_val = cr1;
            default: sel_val = ID0_VALUE;
        endcase
    end

    // Register reads return the value on both lanes, which is word {v, v}.
    assign pre_word = ca0[46] ? {sel_val, sel_val} : mem[addr_ca];

    function automatic logic [31:0] lanes(input logic [31:0] w);
        return {w[31:24], w[15:8], w[23:16], w[7:0]};
    endfunction

    // Latency CK count is 2L (fixed 2x latency).
    function automatic logic [4:0] lat2(input logic [3:0] code);
        case (code)
            4'h0:    return 5'd10;
            4'h1:    return 5'd12;
            4'h2:    return 5'd14;
            4'hE:    return 5'd6;
            4'hF:    return 5'd8;
            default: return 5'd12;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (state == WRDATA && dram_ck_en && !dram_cs) begin
            if (!dram_rwds_rise[1]) mem[addr][31:24] <= dram_dq_rise[15:8];
            if (!dram_rwds_fall[1]) mem[addr][23:16] <= dram_dq_fall[15:8];
            if (!dram_rwds_rise[0]) mem[addr][15:8]  <= dram_dq_rise[7:0];
            if (!dram_rwds_fall[0]) mem[addr][7:0]   <= dram_dq_fall[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            armed              <= 1'b0;
            ck_cnt             <= '0;
            lat_cnt            <= '0;
            ca0_hi             <= '0;
            ca1_hi             <= '0;
            addr               <= '0;
            is_rd              <= 1'b0;
            is_reg             <= 1'b0;
            reg_done           <= 1'b0;
            reg_sel            <= '0;
            cr0                <= 16'h8F1F;
            cr1                <= 16'h0002;
            dram_dq_out_rise   <= '0;
            dram_dq_out_fall   <= '0;
            dram_dq_oe         <= 1'b0;
            dram_rwds_out_rise <= '0;
            dram_rwds_out_fall <= '0;
            dram_rwds_oe       <= 1'b0;
            busy               <= 1'b0;
            err                <= 1'b0;
        end else begin
            err <= 1'b0;
            if (dram_cs) begin
                // Only a fresh CS# fall after seeing it high starts a command.
                armed              <= 1'b1;
                state              <= IDLE;
                busy               <= 1'b0;
                dram_dq_oe         <= 1'b0;
                dram_rwds_oe       <= 1'b0;
                dram_rwds_out_rise <= '0;
                dram_rwds_out_fall <= '0;
            end else begin
                case (state)
                    IDLE: if (armed) begin
                        armed              <= 1'b0;
                        state              <= CA;
                        busy               <= 1'b1;
                        dram_rwds_oe       <= 1'b1;
                        dram_rwds_out_rise <= 2'b11;
                        dram_rwds_out_fall <= 2'b11;
                        ck_cnt             <= dram_ck_en ? 2'd1 : 2'd0;
                        if (dram_ck_en) begin
                            ca0_hi <= {ca0_hi[15:0], dram_dq_rise[7:0],  dram_dq_fall[7:0]};
                            ca1_hi <= {ca1_hi[15:0], dram_dq_rise[15:8], dram_dq_fall[15:8]};
                        end
                    end
                    CA: if (dram_ck_en) begin
                        if (ck_cnt == 2'd2) begin
                            dram_rwds_oe       <= 1'b0;
                            dram_rwds_out_rise <= '0;
                            dram_rwds_out_fall <= '0;
                            if (ca_bad) begin
                                state <= IGNORE;
                                err   <= 1'b1;
                            end else begin
                                is_rd    <= ca0[47];
                                is_reg   <= ca0[46];
                                reg_sel  <= sel_d;
                                reg_done <= 1'b0;
                                addr     <= addr_ca;
                                if (!ca0[47] && ca0[46]) begin
                                    state <= REGWR;
                                end else begin
                                    state   <= LAT;
                                    lat_cnt <= lat2(cr0[7:4]);
                                    if (ca0[47])
                                        {dram_dq_out_rise, dram_dq_out_fall} <= lanes(pre_word);
                                end
                            end
                        end else begin
                            ca0_hi <= {ca0_hi[15:0], dram_dq_rise[7:0],  dram_dq_fall[7:0]};
                            ca1_hi <= {ca1_hi[15:0], dram_dq_rise[15:8], dram_dq_fall[15:8]};
                            ck_cnt <= ck_cnt + 2'd1;
                        end
                    end
                    LAT: if (dram_ck_en) begin
                        if (lat_cnt == 5'd1) begin
                            state <= is_rd ? RDDATA : WRDATA;
                            if (is_rd) begin
                                dram_dq_oe         <= 1'b1;
                                dram_rwds_oe       <= 1'b1;
                                dram_rwds_out_rise <= 2'b11;
                                dram_rwds_out_fall <= 2'b00;
                            end
                        end else begin
                            lat_cnt <= lat_cnt - 5'd1;
                        end
                    end
                    RDDATA: if (dram_ck_en) begin
                        addr <= addr_nxt;
                        if (!is_reg)
                            {dram_dq_out_rise, dram_dq_out_fall} <= lanes(mem[addr_nxt]);
                    end
                    WRDATA: if (dram_ck_en) addr <= addr_nxt;
                    REGWR: if (dram_ck_en && !reg_done) begin
                        reg_done <= 1'b1;
                        if (reg_sel == 2'd1)
                            cr0 <= {dram_dq_rise[7:0], dram_dq_fall[7:0]};
                        else if (reg_sel == 2'd2)
                            cr1 <= {dram_dq_rise[7:0], dram_dq_fall[7:0]};
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hyperram_responder.sv
// Directed bench for hyperram_responder: register access, masked writes,
// read latency timing, address wrap, command rejection and mid-bus reset.
module tb_hyperram_responder;

    logic        clk = 1'b0, rst_n = 1'b0, cs = 1'b1, ck_en = 1'b0;
    logic [15:0] dr = '0, df = '0;
    logic [1:0]  rr = '0, rf = '0;
    logic [15:0] dq_out_rise, dq_out_fall;
    logic        dq_oe, rwds_oe, busy, err;
    logic [1:0]  rwds_out_rise, rwds_out_fall;

    int n_cmp = 0, n_bad = 0, err_cnt = 0;
    logic [31:0] wd   [8];
    logic [1:0]  wmr  [8];
    logic [1:0]  wmf  [8];
    logic [31:0] rexp [8];

    hyperram_responder dut (
        .clk(clk), .rst_n(rst_n), .dram_cs(cs), .dram_ck_en(ck_en),
        .dram_dq_rise(dr), .dram_dq_fall(df),
        .dram_rwds_rise(rr), .dram_rwds_fall(rf),
        .dram_dq_out_rise(dq_out_rise), .dram_dq_out_fall(dq_out_fall),
        .dram_dq_oe(dq_oe), .dram_rwds_out_rise(rwds_out_rise),
        .dram_rwds_out_fall(rwds_out_fall), .dram_rwds_oe(rwds_oe),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (err === 1'b1) err_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mk_ca(input logic rd, input logic rg, input logic lin,
                                          input logic [31:0] a);
        return {rd, rg, lin, a[31:3], 13'd0, a[2:0]};
    endfunction

    function automatic logic [31:0] dq_of(input logic [31:0] w);
        return {w[31:24], w[15:8], w[23:16], w[7:0]};
    endfunction

    task automatic tick(input logic [15:0] r, input logic [15:0] f,
                        input logic [1:0] mr, input logic [1:0] mf);
        @(negedge clk);
        cs = 1'b0; ck_en = 1'b1; dr = r; df = f; rr = mr; rf = mf;
    endtask

    task automatic sel();
        @(negedge clk);
        cs = 1'b0; ck_en = 1'b0;
    endtask

    task automatic send_ca(input logic [47:0] c0, input logic [47:0] c1, input logic ca_drive);
        for (int k = 0; k < 3; k++) begin
            tick({c1[47-16*k -: 8], c0[47-16*k -: 8]}, {c1[39-16*k -: 8], c0[39-16*k -: 8]},
                 2'b00, 2'b00);
            if (k == 0)
                chk("ca_rwds", {27'd0, rwds_oe, rwds_out_rise, rwds_out_fall},
                    ca_drive ? 32'h1F : 32'h0);
        end
    endtask

    task automatic desel(input string tag, input logic exp_oe);
        @(negedge clk);
        chk({tag, "_oe_last"}, {31'd0, dq_oe}, {31'd0, exp_oe});
        cs = 1'b1; ck_en = 1'b0;
        @(negedge clk);
        chk({tag, "_oe_off"}, {29'd0, dq_oe, rwds_oe, busy}, 32'd0);
    endtask

    task automatic do_write(input logic [47:0] c0, input logic [47:0] c1, input int lat,
                            input int n, input string tag);
        logic drv;
        drv = 1'b0;
        sel();
        send_ca(c0, c1, 1'b1);
        for (int i = 0; i < 2*lat; i++) begin
            tick(16'hA5A5, 16'h5A5A, 2'b00, 2'b00);
            drv |= dq_oe | rwds_oe;
        end
        for (int j = 0; j < n; j++) begin
            tick({wd[j][31:24], wd[j][15:8]}, {wd[j][23:16], wd[j][7:0]}, wmr[j], wmf[j]);
            drv |= dq_oe | rwds_oe;
        end
        chk({tag, "_nodrive"}, {31'd0, drv}, 32'd0);
        desel(tag, 1'b0);
    endtask

    task automatic do_read(input logic [47:0] c, input int lat, input int n, input string tag);
        sel();
        send_ca(c, c, 1'b1);
        for (int i = 0; i < 2*lat; i++) begin
            tick(16'h0, 16'h0, 2'b00, 2'b00);
            if (i == 2*lat-1) chk({tag, "_oe_pre"}, {31'd0, dq_oe}, 32'd0);
        end
        for (int j = 0; j < n; j++) begin
            tick(16'h0, 16'h0, 2'b00, 2'b00);
            chk($sformatf("%s_ctl%0d", tag, j),
                {26'd0, dq_oe, rwds_oe, rwds_out_rise, rwds_out_fall}, 32'b11_11_00);
            chk($sformatf("%s_d%0d", tag, j), {dq_out_rise, dq_out_fall}, dq_of(rexp[j]));
        end
        desel(tag, 1'b1);
    endtask

    task automatic set_w(input int j, input logic [31:0] w);
        wd[j] = w; wmr[j] = 2'b00; wmf[j] = 2'b00;
    endtask

    initial begin
        int e0;
        #12;
        chk("rst_ctl", {26'd0, dq_oe, rwds_oe, busy, err, rwds_out_rise[0], rwds_out_fall[0]}
                       | {30'd0, rwds_out_rise[1], rwds_out_fall[1]}, 32'd0);
        chk("rst_dq", {dq_out_rise, dq_out_fall}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);

        rexp[0] = 32'h8F1F8F1F; rexp[1] = 32'h8F1F8F1F;
        do_read(mk_ca(1, 1, 1, 32'h800), 6, 2, "cr0_rst");

        set_w(0, 32'hDEADBEEF); set_w(1, 32'h12345678);
        do_write(mk_ca(0, 0, 1, 32'h10), mk_ca(0, 0, 1, 32'h10), 6, 2, "wr10");
        rexp[0] = 32'hDEADBEEF; rexp[1] = 32'h12345678;
        do_read(mk_ca(1, 0, 1, 32'h10), 6, 2, "rd10");

        set_w(0, 32'h0);
        do_write(mk_ca(0, 0, 1, 0), mk_ca(0, 0, 1, 0), 6, 1, "clr0");
        set_w(0, 32'hAABBCCDD); wmr[0] = 2'b01;
        do_write(mk_ca(0, 0, 1, 0), mk_ca(0, 0, 1, 0), 6, 1, "mask0");
        rexp[0] = 32'hAABB00DD;
        do_read(mk_ca(1, 0, 1, 0), 6, 1, "rdmask");

        set_w(0, 32'h55667788);
        do_write(mk_ca(0, 0, 1, 32'h20), mk_ca(0, 0, 1, 32'h20), 6, 1, "wr20");
        set_w(0, 32'hCAFEF00D);
        do_write(mk_ca(0, 0, 1, 32'h30), mk_ca(0, 0, 1, 32'h30), 6, 1, "wr30");

        set_w(0, 32'h11111111); set_w(1, 32'h22222222); set_w(2, 32'h33333333);
        do_write(mk_ca(0, 0, 1, 1023), mk_ca(0, 0, 1, 1023), 6, 3, "wrap");
        rexp[0] = 32'h11111111;
        do_read(mk_ca(1, 0, 1, 1023), 6, 1, "rdtop");
        rexp[0] = 32'h22222222; rexp[1] = 32'h33333333;
        do_read(mk_ca(1, 0, 1, 0), 6, 2, "rdbot");

        e0 = err_cnt;
        set_w(0, 32'h01020304);
        do_write(mk_ca(0, 0, 1, 32'h30), mk_ca(0, 0, 1, 32'h30) ^ (48'h1 << 20), 6, 1, "rejlane");
        chk("rejlane_err", err_cnt - e0, 1);
        e0 = err_cnt;
        do_write(mk_ca(0, 0, 0, 32'h30), mk_ca(0, 0, 0, 32'h30), 6, 1, "rejwrap");
        chk("rejwrap_err", err_cnt - e0, 1);
        rexp[0] = 32'hCAFEF00D;
        do_read(mk_ca(1, 0, 1, 32'h30), 6, 1, "rdrej");

        set_w(0, 32'h00008FEF);
        do_write(mk_ca(0, 1, 1, 32'h800), mk_ca(0, 1, 1, 32'h800), 0, 1, "wrcr0");
        rexp[0] = 32'h8FEF8FEF;
        do_read(mk_ca(1, 1, 1, 32'h800), 3, 1, "rdcr0");
        rexp[0] = 32'hDEADBEEF;
        do_read(mk_ca(1, 0, 1, 32'h10), 3, 1, "rdl3");
        set_w(0, 32'h00000003);
        do_write(mk_ca(0, 1, 1, 32'h808), mk_ca(0, 1, 1, 32'h808), 0, 1, "wrcr1");
        rexp[0] = 32'h00030003;
        do_read(mk_ca(1, 1, 1, 32'h808), 3, 1, "rdcr1");
        set_w(0, 32'h00001234);
        do_write(mk_ca(0, 1, 1, 0), mk_ca(0, 1, 1, 0), 0, 1, "wrid0");
        rexp[0] = 32'h0C810C81;
        do_read(mk_ca(1, 1, 1, 0), 3, 1, "rdid0");

        // Reset while selected: the rest of this transaction must be ignored.
        sel();
        tick(16'h0, 16'h0, 2'b00, 2'b00);
        @(negedge clk); rst_n = 1'b0;
        #1 chk("midrst", {30'd0, busy, rwds_oe}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        send_ca(mk_ca(0, 0, 1, 32'h20), mk_ca(0, 0, 1, 32'h20), 1'b0);
        for (int i = 0; i < 12; i++) tick(16'h0, 16'h0, 2'b00, 2'b00);
        tick(16'h9999, 16'h9999, 2'b00, 2'b00);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        desel("midrst", 1'b0);
        rexp[0] = 32'h55667788;
        do_read(mk_ca(1, 0, 1, 32'h20), 6, 1, "rdmid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
